adder_rr_arbiter: RTL and testbench



---
 rtl/adder_arb_pkg.sv | 42 ++++
 rtl/carry_select_adder16.sv | 44 ++++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/adder_rr_arbiter.sv | 134 +++++++++++++
 tb/tb_adder_rr_arbiter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/adder_arb_pkg.sv
// ---------------------------------------------------------------------------
// adder_arb_pkg
// Shared constants, types and helpers for the round-robin shared adder.
//   DATA_W     : operand / sum width
//   MAX_REQ    : largest supported requester count
//   id_width() : requester index width for a given requester count
//   res_rec_t  : result record (sum, id, optional signed-overflow flag)
//   signed_ovf(): signed overflow detection for an A+B sum
// Optional feature macro: ADDER_ARB_OVF_FLAG_EN (adds the ovf field).
// ---------------------------------------------------------------------------
package adder_arb_pkg;

    localparam int DATA_W  = 16;
    localparam int MAX_REQ = 8;

    // Index width needed to address n requesters (at least one bit).
    function automatic int id_width(input int n);
        if (n > 2) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    localparam int MAX_ID_W = id_width(MAX_REQ);

    typedef struct packed {
        logic [DATA_W-1:0]   sum;
        logic [MAX_ID_W-1:0] id;
`ifdef ADDER_ARB_OVF_FLAG_EN
        logic                ovf;
`endif
    } res_rec_t;

    // Signed overflow: operands agree in sign but the wrapped sum does not.
    function automatic logic signed_ovf(input logic [DATA_W-1:0] a,
                                        input logic [DATA_W-1:0] b,
                                        input logic [DATA_W-1:0] s);
        return (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
    endfunction

endpackage

// File: rtl/carry_select_adder16.sv
// ---------------------------------------------------------------------------
// carrySelectAdder16bit
// 16-bit carry-select adder built from four 4-bit blocks. The lowest block
// ripples; each upper block precomputes its sum for carry-in 0 and 1 and the
// real carry selects between them. The carry out of bit 15 is not produced,
// so the result is the sum modulo 2^16.
// Ports:
//   a, b : 16-bit operands
//   sum  : (a + b) mod 2^16
// ---------------------------------------------------------------------------
module carrySelectAdder16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum
);

    logic [4:0] blk0_s;
    logic [4:0] blk1_c0_s, blk1_c1_s;
    logic [4:0] blk2_c0_s, blk2_c1_s;
    logic [3:0] blk3_c0_s, blk3_c1_s;
    logic       c1_s, c2_s, c3_s;

    assign blk0_s    = {1'b0, a[3:0]} + {1'b0, b[3:0]};

    assign blk1_c0_s = {1'b0, a[7:4]} + {1'b0, b[7:4]};
    assign blk1_c1_s = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;

    assign blk2_c0_s = {1'b0, a[11:8]} + {1'b0, b[11:8]};
    assign blk2_c1_s = {1'b0, a[11:8]} + {1'b0, b[11:8]} + 5'd1;

    // Top block needs no carry out: the result wraps at 16 bits.
    assign blk3_c0_s = a[15:12] + b[15:12];
    assign blk3_c1_s = a[15:12] + b[15:12] + 4'd1;

    assign c1_s = blk0_s[4];
    assign c2_s = c1_s ? blk1_c1_s[4] : blk1_c0_s[4];
    assign c3_s = c2_s ? blk2_c1_s[4] : blk2_c0_s[4];

    assign sum = {c3_s ? blk3_c1_s      : blk3_c0_s,
                  c2_s ? blk2_c1_s[3:0] : blk2_c0_s[3:0],
                  c1_s ? blk1_c1_s[3:0] : blk1_c0_s[3:0],
                  blk0_s[3:0]};

endmodule

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational rotating-priority pick: starting at ptr and wrapping modulo
// N, the first asserted valid bit wins.
// Ports:
//   valid     : N request bits
//   ptr       : index holding highest priority this cycle
//   grant     : one-hot winner (zero when nothing is valid)
//   grant_idx : binary index of the winner (zero when nothing is valid)
//   any_grant : some request was granted
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = (N > 2) ? $clog2(N) : 1
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic         any_grant
);

    int idx_s;

    // Walk offsets from farthest to nearest so the nearest valid index wins.
    always_comb begin
        idx_s     = 0;
        grant_idx = {W{1'b0}};
        any_grant = 1'b0;
        for (int off = N - 1; off >= 0; off--) begin
            idx_s = (int'(ptr) + off) % N;
            if (valid[idx_s]) begin
                grant_idx = W'(idx_s);
                any_grant = 1'b1;
            end else begin
                any_grant = any_grant;
            end
        end
        if (any_grant) begin
            grant = {{(N-1){1'b0}}, 1'b1} << grant_idx;
        end else begin
            grant = {N{1'b0}};
        end
    end

endmodule

// File: rtl/adder_rr_arbiter.sv
// ---------------------------------------------------------------------------
// adder_rr_arbiter
// Shares one 16-bit carry-select adder between NUM_REQ requesters. One
// round-robin grant per cycle; the granted pair is summed combinationally
// and captured with its requester index in a one-entry output register
// behind a valid/ready handshake (one add per cycle without stalls).
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   req_valid  : per-requester operand-pair valid
//   req_ready  : per-requester accept, one-hot or zero (combinational,
//                depends on res_ready)
//   req_a/b    : operands, requester i at bits [16*i+15:16*i]
//   res_valid  : output register holds a result
//   res_ready  : consumer accepts the result
//   res_sum    : registered (A+B) mod 2^16
//   res_id     : requester that produced res_sum
//   res_ovf    : signed overflow flag (only with ADDER_ARB_OVF_FLAG_EN)
// Optional feature macro: ADDER_ARB_OVF_FLAG_EN.
// ---------------------------------------------------------------------------
module adder_rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [DATA_W-1:0]         res_sum,
    output logic [ID_W-1:0]           res_id
`ifdef ADDER_ARB_OVF_FLAG_EN
    ,
    output logic                      res_ovf
`endif
);

    logic [ID_W-1:0]    rr_ptr_r;
    logic               res_valid_r;
    logic [DATA_W-1:0]  res_sum_r;
    logic [ID_W-1:0]    res_id_r;

    logic [NUM_REQ-1:0] grant_s;
    logic [ID_W-1:0]    grant_idx_s;
    logic               any_grant_s;
    logic               slot_free_s;
    logic               accept_s;
    logic [DATA_W-1:0]  a_sel_s;
    logic [DATA_W-1:0]  b_sel_s;
    logic [DATA_W-1:0]  sum_s;
    logic [ID_W-1:0]    next_ptr_s;

    rr_arbiter #(
        .N (NUM_REQ),
        .W (ID_W)
    ) u_rr_arbiter (
        .valid     (req_valid),
        .ptr       (rr_ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .any_grant (any_grant_s)
    );

    carrySelectAdder16bit u_adder (
        .a   (a_sel_s),
        .b   (b_sel_s),
        .sum (sum_s)
    );

    // Handshake, operand mux and pointer advance for the current grant.
    // req_ready is forced low while rst_n is asserted so nothing is taken.
    always_comb begin
        slot_free_s = !res_valid_r || res_ready;
        accept_s    = any_grant_s && slot_free_s && rst_n;
        if (slot_free_s && rst_n) begin
            req_ready = grant_s;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
        a_sel_s = req_a[int'(grant_idx_s)*DATA_W +: DATA_W];
        b_sel_s = req_b[int'(grant_idx_s)*DATA_W +: DATA_W];
        if (grant_idx_s == ID_W'(NUM_REQ - 1)) begin
            next_ptr_s = {ID_W{1'b0}};
        end else begin
            next_ptr_s = grant_idx_s + ID_W'(1'b1);
        end
    end

    // Output register and round-robin pointer. Accept overrides drain so a
    // simultaneous drain+accept replaces the result with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r    <= {ID_W{1'b0}};
            res_valid_r <= 1'b0;
            res_sum_r   <= {DATA_W{1'b0}};
            res_id_r    <= {ID_W{1'b0}};
        end else if (accept_s) begin
            rr_ptr_r    <= next_ptr_s;
            res_valid_r <= 1'b1;
            res_sum_r   <= sum_s;
            res_id_r    <= grant_idx_s;
        end else if (res_ready) begin
            res_valid_r <= 1'b0;
        end else begin
            res_valid_r <= res_valid_r;
        end
    end

`ifdef ADDER_ARB_OVF_FLAG_EN
    logic res_ovf_r;

    // Overflow flag travels with the sum and holds under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_ovf_r <= 1'b0;
        end else if (accept_s) begin
            res_ovf_r <= signed_ovf(a_sel_s, b_sel_s, sum_s);
        end else begin
            res_ovf_r <= res_ovf_r;
        end
    end

    assign res_ovf = res_ovf_r;
`endif

    assign res_valid = res_valid_r;
    assign res_sum   = res_sum_r;
    assign res_id    = res_id_r;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_adder_rr_arbiter
// Self-checking bench for adder_rr_arbiter (NUM_REQ=4): directed scenarios
// followed by randomized traffic, compared against a behavioural model.
// Optional feature macro: ADDER_ARB_OVF_FLAG_EN (checks res_ovf too).
// ---------------------------------------------------------------------------
module tb_adder_rr_arbiter;
    import adder_arb_pkg::*;

    localparam int N   = 4;
    localparam int IDW = $clog2(N);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_ready;
    logic [N*DATA_W-1:0]  req_a;
    logic [N*DATA_W-1:0]  req_b;
    logic                 res_valid;
    logic                 res_ready;
    logic [DATA_W-1:0]    res_sum;
    logic [IDW-1:0]       res_id;
`ifdef ADDER_ARB_OVF_FLAG_EN
    logic                 res_ovf;
`endif

    adder_rr_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_id    (res_id)
`ifdef ADDER_ARB_OVF_FLAG_EN
        ,
        .res_ovf   (res_ovf)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Requester-side state: pending operand pair per requester.
    bit          va [N];
    logic [15:0] aa [N];
    logic [15:0] ba [N];

    // Reference model state: priority pointer and the expected output record.
    int       m_ptr;
    bit       m_valid;
    res_rec_t m_res;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]               = va[i];
            req_a[i*DATA_W +: DATA_W]  = aa[i];
            req_b[i*DATA_W +: DATA_W]  = ba[i];
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_res   = '0;
    endtask

    // First pending requester at or after the pointer, wrapping; -1 if none.
    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            if (va[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic check_outputs(input string tag);
        check_val({tag, "_res_valid"}, 32'(res_valid), 32'(m_valid));
        check_val({tag, "_res_sum"}, 32'(res_sum), 32'(m_res.sum));
        check_val({tag, "_res_id"}, 32'(res_id), 32'(m_res.id));
`ifdef ADDER_ARB_OVF_FLAG_EN
        check_val({tag, "_res_ovf"}, 32'(res_ovf), 32'(m_res.ovf));
`endif
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic cycle(input string tag);
        int           g;
        int           ssum;
        bit           slot_free;
        logic [N-1:0] exp_rdy;
        drive();
        #1;
        slot_free = !m_valid || res_ready;
        g         = pick();
        exp_rdy   = '0;
        if (g >= 0 && slot_free) exp_rdy[g] = 1'b1;
        check_val({tag, "_req_ready"}, 32'(req_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        if (g >= 0 && slot_free) begin
            ssum      = int'($signed(aa[g])) + int'($signed(ba[g]));
            m_res.sum = 16'(int'(aa[g]) + int'(ba[g]));
            m_res.id  = 3'(g);
`ifdef ADDER_ARB_OVF_FLAG_EN
            m_res.ovf = (ssum > 32767) || (ssum < -32768);
`endif
            m_valid   = 1'b1;
            m_ptr     = (g + 1) % N;
            va[g]     = 1'b0;
        end else if (m_valid && res_ready) begin
            m_valid = 1'b0;
        end
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic arm(input int i, input logic [15:0] a, input logic [15:0] b);
        va[i] = 1'b1;
        aa[i] = a;
        ba[i] = b;
    endtask

    initial begin
        rst_n     = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < N; i++) arm(i, 16'(i * 16'h0101), 16'(16'h1000 + i));
        drive();
        model_reset();

        // Reset: requests pending but nothing may be accepted.
        @(negedge clk);
        @(negedge clk);
        check_val("rst_req_ready", 32'(req_ready), 32'd0);
        check_val("rst_res_valid", 32'(res_valid), 32'd0);
        rst_n = 1'b1;
        cycle("rst_first");
        check_val("rst_rr_ptr", 32'(dut.rr_ptr_r), 32'd1);

        // Round robin with every requester continuously valid.
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) if (!va[i]) arm(i, 16'($urandom), 16'($urandom));
            cycle("rr");
            check_val("rr_id_seq", 32'(res_id), 32'((k + 1) % N));
        end

        // Drain, then a single requester.
        for (int i = 0; i < N; i++) va[i] = 1'b0;
        cycle("drain");
        arm(2, 16'h1234, 16'h0F0F);
        cycle("single");
        check_val("single_sum_const", 32'(res_sum), 32'h2143);

        // Backpressure: three stalled cycles, then release loads req 1.
        res_ready = 1'b0;
        arm(1, 16'hABCD, 16'h1111);
        for (int k = 0; k < 3; k++) cycle("stall");
        res_ready = 1'b1;
        cycle("unstall");
        check_val("unstall_id_const", 32'(res_id), 32'd1);

        // Wrap-around arithmetic.
        arm(3, 16'hFFFF, 16'h0002);
        cycle("wrap");
        check_val("wrap_sum_const", 32'(res_sum), 32'h0001);
        arm(0, 16'h7FFF, 16'h0001);
        cycle("ovf");
        check_val("ovf_sum_const", 32'(res_sum), 32'h8000);
`ifdef ADDER_ARB_OVF_FLAG_EN
        check_val("ovf_flag_const", 32'(res_ovf), 32'd1);
`endif

        // Asynchronous reset in the middle of a stall.
        res_ready = 1'b0;
        arm(2, 16'h0003, 16'h0004);
        cycle("pre_rst_stall");
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_res_valid", 32'(res_valid), 32'd0);
        check_val("async_rst_req_ready", 32'(req_ready), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n     = 1'b1;
        res_ready = 1'b1;
        cycle("post_rst");

        // Randomized traffic with random backpressure.
        for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!va[i] && ($urandom_range(0, 1) == 0)) begin
                    case ($urandom_range(0, 3))
                        0:       arm(i, 16'hFFFF, 16'($urandom));
                        1:       arm(i, 16'h7FFF, 16'($urandom_range(0, 3)));
                        default: arm(i, 16'($urandom), 16'($urandom));
                    endcase
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
